// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of one async-read / sync-write RAM.
// Optional zero-fill sweep after reset; one RAM access per cycle.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  requester A access (held until a_gnt)
//   a_gnt                      A access performed this cycle (comb.)
//   a_rvalid/a_rdata           A read result, one cycle after read grant
//   b_*                        same set for requester B
//   ram_addr/ram_data          RAM async read port
//   ram_wraddr/ram_wrdata/ram_we  RAM sync write port
//   busy                       clear sweep in progress
module ram_arbiter #(
    parameter int AWIDTH         = 4,
    parameter int DWIDTH         = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DWIDTH-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DWIDTH-1:0] b_rdata,

    output logic [AWIDTH-1:0] ram_addr,
    input  logic [DWIDTH-1:0] ram_data,
    output logic [AWIDTH-1:0] ram_wraddr,
    output logic [DWIDTH-1:0] ram_wrdata,
    output logic              ram_we,
    output logic              busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;
    localparam logic [AWIDTH-1:0] LAST_WORD = '1;

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] cnt;
    logic [AWIDTH-1:0] last_raddr;
    // 0: A wins the next conflict, 1: B wins it
    logic              prio;
    logic              serve;
    logic              clr_we;
    logic              a_rd;
    logic              b_rd;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (cnt == LAST_WORD) state_nxt = SERVE;
            SERVE:   state_nxt = SERVE;
            default: state_nxt = RST_STATE;
        endcase
    end

    // ---------------- grants ----------------
    // Grants and RAM writes are masked while rst is high so nothing
    // commits on the reset edge.
    assign serve  = (state == SERVE) && !rst;
    assign clr_we = (state == CLEAR) && !rst;

    assign a_gnt = serve && a_req && (!b_req || !prio);
    assign b_gnt = serve && b_req && (!a_req || prio);

    assign a_rd = a_gnt && !a_we;
    assign b_rd = b_gnt && !b_we;

    // ---------------- outputs ----------------
    always_comb begin
        ram_we     = 1'b0;
        ram_wraddr = cnt;
        ram_wrdata = '0;
        ram_addr   = last_raddr;
        busy       = (state == CLEAR);
        unique case (1'b1)
            clr_we: begin
                ram_we = 1'b1;
            end
            a_gnt: begin
                if (a_we) begin
                    ram_we     = 1'b1;
                    ram_wraddr = a_addr;
                    ram_wrdata = a_wdata;
                end else begin
                    ram_addr = a_addr;
                end
            end
            b_gnt: begin
                if (b_we) begin
                    ram_we     = 1'b1;
                    ram_wraddr = b_addr;
                    ram_wrdata = b_wdata;
                end else begin
                    ram_addr = b_addr;
                end
            end
            default: ;
        endcase
    end

    // ---------------- sweep counter ----------------
    // Wraps to 0 on the last word, leaving it at 0 for the next sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
        end
    end

    // ---------------- priority and read returns ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prio       <= 1'b0;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            last_raddr <= '0;
        end else begin
            if (a_gnt) begin
                prio <= 1'b1;
            end else if (b_gnt) begin
                prio <= 1'b0;
            end
            a_rvalid <= a_rd;
            b_rvalid <= b_rd;
            if (a_rd) a_rdata <= ram_data;
            if (b_rd) b_rdata <= ram_data;
            // Hold the read address while idle to keep ram_addr quiet.
            if (a_rd || b_rd) last_raddr <= ram_addr;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM model.
// Expected values are hand-computed constants.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       fill;
    logic       a_req, a_we, b_req, b_we;
    logic [3:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [3:0] a_rdata, b_rdata;
    logic [3:0] ram_addr, ram_data, ram_wraddr, ram_wrdata;
    logic       ram_we, busy;
    logic [3:0] mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .AWIDTH(4), .DWIDTH(4), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_wraddr(ram_wraddr), .ram_wrdata(ram_wrdata),
        .ram_we(ram_we), .busy(busy)
    );

    // RAM model: async read, write at clock edge; fill preloads 0xF
    assign ram_data = mem[ram_addr];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'hF;
        end else if (ram_we) begin
            mem[ram_wraddr] <= ram_wrdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            neg();
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_we"}, ram_we, 1);
            chk({tag, "_wraddr"}, ram_wraddr, i);
            chk({tag, "_wrdata"}, ram_wrdata, 0);
            chk({tag, "_agnt"}, a_gnt, 0);
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1; fill = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        cyc();
        fill = 1'b0;
        cyc();
        // reset state
        neg();
        chk("rst_busy", busy, 1);
        chk("rst_we", ram_we, 0);
        chk("rst_arvalid", a_rvalid, 0);
        chk("rst_ardata", a_rdata, 0);
        chk("rst_brvalid", b_rvalid, 0);
        cyc();
        rst = 1'b0;

        // 1: clear sweep, then read addr 7 (preloaded 0xF)
        sweep("t1");
        neg();
        chk("t1_busy_low", busy, 0);
        chk("t1_idle_we", ram_we, 0);
        cyc();
        a_req = 1; a_we = 0; a_addr = 7;
        neg();
        chk("t1_agnt", a_gnt, 1);
        cyc();
        a_req = 0;
        neg();
        chk("t1_rvalid", a_rvalid, 1);
        chk("t1_rdata", a_rdata, 0);
        cyc();
        neg();
        chk("t1_rvalid_pulse", a_rvalid, 0);

        // 2: write 5<-A then read 5
        cyc();
        a_req = 1; a_we = 1; a_addr = 5; a_wdata = 4'hA;
        neg();
        chk("t2_wgnt", a_gnt, 1);
        chk("t2_we", ram_we, 1);
        chk("t2_wraddr", ram_wraddr, 5);
        chk("t2_wrdata", ram_wrdata, 4'hA);
        cyc();
        a_we = 0;
        neg();
        chk("t2_rgnt", a_gnt, 1);
        chk("t2_norvalid", a_rvalid, 0);
        cyc();
        a_req = 0;
        neg();
        chk("t2_rvalid", a_rvalid, 1);
        chk("t2_rdata", a_rdata, 4'hA);

        // 4: B alone three cycles, then conflict -> A first
        cyc();
        b_req = 1; b_we = 1; b_addr = 1; b_wdata = 4'h3;
        neg();
        chk("t4_b0", b_gnt, 1);
        cyc();
        b_addr = 2; b_wdata = 4'hC;
        neg();
        chk("t4_b1", b_gnt, 1);
        cyc();
        b_we = 0;
        neg();
        chk("t4_b2", b_gnt, 1);
        cyc();
        a_req = 1; a_we = 0; a_addr = 1;
        neg();
        chk("t4_conf_a", a_gnt, 1);
        chk("t4_conf_b", b_gnt, 0);
        chk("t4_brvalid", b_rvalid, 1);
        chk("t4_brdata", b_rdata, 4'hC);
        cyc();
        a_req = 0;
        neg();
        chk("t4_next_b", b_gnt, 1);
        chk("t4_arvalid", a_rvalid, 1);
        chk("t4_ardata", a_rdata, 4'h3);

        // 3: both request every cycle -> A,B,A,B
        cyc();
        a_req = 1;
        for (int k = 0; k < 4; k++) begin
            neg();
            chk("t3_agnt", a_gnt, (k % 2 == 0) ? 1 : 0);
            chk("t3_bgnt", b_gnt, (k % 2 == 0) ? 0 : 1);
            chk("t3_arvalid", a_rvalid, (k % 2 == 0) ? 0 : 1);
            chk("t3_brvalid", b_rvalid, (k % 2 == 0) ? 1 : 0);
            if (k % 2 == 0) chk("t3_brdata", b_rdata, 4'hC);
            else            chk("t3_ardata", a_rdata, 4'h3);
            cyc();
        end
        a_req = 0; b_req = 0;
        neg();
        chk("t3_end_brvalid", b_rvalid, 1);
        chk("t3_end_brdata", b_rdata, 4'hC);
        chk("t3_end_arvalid", a_rvalid, 0);

        // 6: read grant then reset -> rvalid/rdata cleared
        cyc();
        a_req = 1; a_we = 0; a_addr = 5;
        neg();
        chk("t6_gnt", a_gnt, 1);
        cyc();
        rst = 1'b1;
        neg();
        chk("t6_rst_gnt", a_gnt, 0);
        chk("t6_rst_we", ram_we, 0);
        cyc();
        neg();
        chk("t6_rvalid", a_rvalid, 0);
        chk("t6_rdata", a_rdata, 0);
        chk("t6_busy", busy, 1);
        cyc();
        rst = 1'b0;

        // 5: reset at sweep cycle 6 restarts sweep; held a_req waits
        for (int i = 0; i < 6; i++) begin
            neg();
            chk("t5_pre_wraddr", ram_wraddr, i);
            chk("t5_pre_agnt", a_gnt, 0);
            cyc();
        end
        rst = 1'b1;
        neg();
        chk("t5_rst_we", ram_we, 0);
        chk("t5_rst_busy", busy, 1);
        cyc();
        rst = 1'b0;
        sweep("t5");
        neg();
        chk("t5_busy_low", busy, 0);
        chk("t5_first_gnt", a_gnt, 1);
        cyc();
        a_req = 0;
        neg();
        chk("t5_rvalid", a_rvalid, 1);
        chk("t5_rdata", a_rdata, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
